exe_type_r_md: RTL
==================

Name: exe_type_r_md

Overview:
- Registered, multi-cycle execute unit for RV32 R-type instructions.
- Generalises the single-cycle R-type ALU with a data-width parameter, a valid/ready handshake and the M-extension.
- M-extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, executed by iterative shift-add / restoring-divide datapaths.
- Sits between decode (operands + instruction) and writeback (rd, data, write enable).

Parameters:
- DATA_WIDTH, 32, operand/result width (XLEN); must be a power of two, at least 8.
- SHAMT_W, $clog2(DATA_WIDTH), number of op2 LSBs used as shift amount.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset.
- valid_i  in  1  op1_i/op2_i/inst_i valid this cycle.
- ready_o  out  1  unit can accept an instruction.
- op1_i  in  DATA_WIDTH  rs1 value.
- op2_i  in  DATA_WIDTH  rs2 value.
- inst_i  in  32  full instruction word.
- valid_o  out  1  one-cycle result strobe.
- reg_wdata_o  out  DATA_WIDTH  result.
- reg_we_o  out  1  writeback enable (qualified by valid_o).
- rd_addr_o  out  5  destination register, inst_i[11:7] captured at accept.
- busy_o  out  1  iterative operation in progress.

Behaviour:
- Reset: synchronous, active-high. Clock and reset are the single clk_i and rst_i.
  - Registered outputs after the reset edge: valid_o=0, reg_we_o=0, reg_wdata_o=0, rd_addr_o=0, busy_o=0, state=IDLE.
  - ready_o is combinational from state, so it reads 1 once state=IDLE.
  - Reset mid-operation aborts it; no valid_o is produced for the aborted instruction.
- States and transitions:
  - IDLE: ready_o=1.
  - RUN: busy_o=1, ready_o=0.
  - DONE: ready_o=0, valid_o=1 for exactly one cycle, then IDLE.
- Accept: valid_i && ready_o at a rising edge. Operands, funct3, funct7 and rd are captured. valid_i in any other state is ignored; no queueing.
- Decode:
  - Legal only when opcode=0110011 and funct7 is 0000000, 0100000 or 0000001.
  - funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA). Anything else is illegal.
- Illegal instruction: DONE on the next cycle with reg_we_o=0, reg_wdata_o=0.
- Base ops (funct7 0000000/0100000): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Result is computed at accept; IDLE->DONE, so valid_o is high the cycle after accept (latency 1).
  - Add/sub wrap modulo 2^DATA_WIDTH.
  - Shifts use op2[SHAMT_W-1:0]; SRA replicates op1 MSB.
  - SLT/SLTU return 1 or 0, zero-extended.
- Multiply (funct7=0000001, funct3 000-011): IDLE->RUN, then one partial-product step per cycle for DATA_WIDTH cycles, then DONE.
  - valid_o is high DATA_WIDTH+1 cycles after accept.
  - Operands are sign- or zero-extended to 2*DATA_WIDTH per the op: MULH s*s, MULHSU s*u, MULHU u*u.
  - MUL returns the low half; MULH* return the high half.
- Divide (funct3 100-111): restoring divide on operand magnitudes, DATA_WIDTH iterations, same latency as multiply.
  - Signed ops fix up signs at DONE entry: quotient sign = op1 sign XOR op2 sign; remainder sign = op1 sign.
  - Divide by zero: skips RUN (latency 1). Quotient = all ones (DIV and DIVU); remainder = op1.
  - Signed overflow (op1 = most negative, op2 = -1): skips RUN (latency 1). Quotient = op1, remainder = 0.
- Outputs in DONE: reg_we_o=1 for every legal op, including rd=0 (writeback filters x0).
- Outputs outside DONE: valid_o=0, reg_we_o=0, reg_wdata_o=0. rd_addr_o holds its last captured value.
- Back-to-back: the earliest next accept is the cycle after DONE.
  - Base ops therefore sustain one result every 2 cycles.

Test Plan:
- ADD 0x7FFFFFFF+1 -> 0x80000000, valid_o 1 cycle after accept. SUB 0-1 -> 0xFFFFFFFF. SRA 0x80000000>>4 -> 0xF8000000. SLTU 1<0xFFFFFFFF -> 1.
- MUL -3*7 -> 0xFFFFFFEB. MULH on the same operands -> 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. Each valid_o exactly 33 cycles after accept; busy_o high 32 cycles.
- DIV -7/2 -> quotient 0xFFFFFFFD, REM -> 0xFFFFFFFF. DIVU 5/0 -> 0xFFFFFFFF with latency 1. REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM 0x80000000/-1 -> 0.
- Illegal funct7=0100000 with funct3=111 -> valid_o pulse, reg_we_o=0, reg_wdata_o=0.
- valid_i held high during a DIV -> no extra accepts, single valid_o. rst_i at cycle 10 of a DIV -> no valid_o, ready_o=1 the cycle after reset deasserts, and the next ADD completes normally.
- DATA_WIDTH=16 build: MUL 0x0100*0x0100 -> 0x0000. MULHU on the same operands -> 0x0001, with latency 17.

Source files
------------

// File: rtl/exe_type_r_md.sv
// Registered multi-cycle RV32 R-type execute unit with the M extension.
// Base ops finish one cycle after accept; multiply and divide iterate
// DATA_WIDTH cycles on shift-add / restoring-divide datapaths.
module exe_type_r_md #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    input  logic [31:0]           inst_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  reg_we_o,
    output logic [4:0]            rd_addr_o,
    output logic                  busy_o
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned W2    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = SHAMT_W;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // decode of the incoming instruction
    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [SHAMT_W-1:0] shamt;
    logic               legal, is_m, is_div, div_signed, div_zero, div_ovf, fast;
    logic               accept;

    // captured instruction / iteration state
    logic [2:0]       f3_q;
    logic             is_mul_q;
    logic             op2_sgn_q;
    logic             q_neg_q, r_neg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W2-1:0]    acc_q, mcand_q;
    logic [W-1:0]     mplier_q;
    logic [W-1:0]     quo_q, rem_q, dvs_q;

    // combinational results
    logic [W-1:0]  alu_res, fast_res, iter_res;
    logic [W2-1:0] addend, acc_nxt;
    logic [W:0]    rem_sh;
    logic [W+1:0]  sub;
    logic          borrow;
    logic [W-1:0]  quo_nxt, rem_nxt;
    logic          last_cnt, last_step;

    logic          unused_bits;
    assign unused_bits = ^{inst_i[24:15], sub[W]};

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign shamt  = op2_i[SHAMT_W-1:0];
    assign accept = valid_i && ready_o;

    // legality and routing of the incoming instruction
    always_comb begin
        legal      = (opcode == 7'b0110011) &&
                     ((f7 == 7'b0000000) || (f7 == 7'b0000001) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
        is_m       = legal && (f7 == 7'b0000001);
        is_div     = is_m && f3[2];
        div_signed = !f3[0];
        div_zero   = is_div && (op2_i == '0);
        div_ovf    = is_div && div_signed && (op1_i == MIN_NEG) && (op2_i == '1);
        fast       = !legal || !is_m || div_zero || div_ovf;
    end

    // single-cycle base ALU
    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000:  alu_res = f7[5] ? (op1_i - op2_i) : (op1_i + op2_i);
            3'b001:  alu_res = op1_i << shamt;
            3'b010:  alu_res[0] = $signed(op1_i) < $signed(op2_i);
            3'b011:  alu_res[0] = op1_i < op2_i;
            3'b100:  alu_res = op1_i ^ op2_i;
            3'b101:  alu_res = f7[5] ? $unsigned($signed(op1_i) >>> shamt) : (op1_i >> shamt);
            3'b110:  alu_res = op1_i | op2_i;
            default: alu_res = op1_i & op2_i;
        endcase
    end

    // result for everything that completes directly from IDLE
    always_comb begin
        fast_res = '0;
        if (!legal)        fast_res = '0;
        else if (!is_m)    fast_res = alu_res;
        else if (div_zero) fast_res = f3[1] ? op1_i : '1;
        else if (div_ovf)  fast_res = f3[1] ? '0 : op1_i;
    end

    // one shift-add step; the final signed multiplier bit carries negative weight
    always_comb begin
        last_cnt = (cnt_q == CNT_W'(W - 1));
        addend   = '0;
        if (mplier_q[0]) begin
            addend = (last_cnt && op2_sgn_q) ? -mcand_q : mcand_q;
        end
        acc_nxt = acc_q + addend;
    end

    // one restoring-divide step on magnitudes
    always_comb begin
        rem_sh  = {rem_q, quo_q[W-1]};
        sub     = {1'b0, rem_sh} - {2'b00, dvs_q};
        borrow  = sub[W+1];
        rem_nxt = borrow ? rem_sh[W-1:0] : sub[W-1:0];
        quo_nxt = {quo_q[W-2:0], ~borrow};
    end

    // final iterative result including sign fix-up
    always_comb begin
        iter_res = '0;
        if (is_mul_q) begin
            iter_res = (f3_q[1:0] == 2'b00) ? acc_nxt[W-1:0] : acc_nxt[W2-1:W];
        end else if (f3_q[1]) begin
            iter_res = r_neg_q ? -rem_nxt : rem_nxt;
        end else begin
            iter_res = q_neg_q ? -quo_nxt : quo_nxt;
        end
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = fast ? S_DONE : S_RUN;
            S_RUN:   if (last_cnt) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state-decoded controls
    always_comb begin
        ready_o   = (state_q == S_IDLE);
        last_step = (state_q == S_RUN) && last_cnt;
    end

    // operand capture, iteration and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_wdata_o <= '0;
            rd_addr_o   <= '0;
            busy_o      <= 1'b0;
            f3_q        <= '0;
            is_mul_q    <= 1'b0;
            op2_sgn_q   <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
        end else begin
            valid_o <= (state_d == S_DONE);
            busy_o  <= (state_d == S_RUN);

            if (accept) begin
                f3_q      <= f3;
                is_mul_q  <= !f3[2];
                rd_addr_o <= inst_i[11:7];
                cnt_q     <= '0;
                acc_q     <= '0;
                mcand_q   <= {{W{op1_i[W-1] & (f3[1:0] != 2'b11)}}, op1_i};
                mplier_q  <= op2_i;
                op2_sgn_q <= !f3[1];
                quo_q     <= (div_signed && op1_i[W-1]) ? -op1_i : op1_i;
                dvs_q     <= (div_signed && op2_i[W-1]) ? -op2_i : op2_i;
                rem_q     <= '0;
                q_neg_q   <= div_signed && (op1_i[W-1] ^ op2_i[W-1]);
                r_neg_q   <= div_signed && op1_i[W-1];
            end else if (state_q == S_RUN) begin
                cnt_q    <= cnt_q + CNT_W'(1);
                acc_q    <= acc_nxt;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                quo_q    <= quo_nxt;
                rem_q    <= rem_nxt;
            end

            if (accept && fast) begin
                reg_wdata_o <= fast_res;
                reg_we_o    <= legal;
            end else if (last_step) begin
                reg_wdata_o <= iter_res;
                reg_we_o    <= 1'b1;
            end else begin
                reg_wdata_o <= '0;
                reg_we_o    <= 1'b0;
            end
        end
    end

endmodule
